// File: rtl/mdu_div_ctrl.sv
// mdu_div_ctrl: EX-stage sequencer for RISC-V DIV/DIVU/REM/REMU and W forms.
// Divide-by-zero and signed overflow are resolved locally. All other
// operations go through the iterative divider handshake. The selected result
// is handed to writeback on a valid/ready pair.
//
// state | meaning
// IDLE  | waiting for a request; accepts only when the divider is idle
// ISSUE | operands held on the divider inputs until its result strobe
// RESP  | result presented to writeback until accepted or flushed
// DRAIN | flushed while the divider was busy; wait for it to finish or go idle
module mdu_div_ctrl #(
    parameter int XLEN   = 64,
    parameter int W_BITS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic            req_w,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy,
    output logic            div_valid,
    output logic            div_signed,
    output logic            divw,
    output logic [XLEN-1:0] dividend,
    output logic [XLEN-1:0] divisor,
    output logic            div_flush,
    input  logic            div_ready,
    input  logic            div_out_valid,
    input  logic [XLEN-1:0] div_quot,
    input  logic [XLEN-1:0] div_rema
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]      state;
    logic            op_signed;
    logic            op_rem;
    logic            op_w;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] resp_q;

    logic            req_signed;
    logic            req_rem;
    logic            accept;
    logic [XLEN-1:0] eff_rs1;
    logic [XLEN-1:0] eff_rs2;
    logic            div_zero;
    logic            most_neg;
    logic            minus_one;
    logic            special;
    logic [XLEN-1:0] special_raw;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] div_res;

    // W results are sign-extended from bit 31 even for the unsigned forms.
    function automatic logic [XLEN-1:0] fmt_result(input logic [XLEN-1:0] val,
                                                   input logic            is_w);
        if (is_w) begin
            return {{(XLEN-W_BITS){val[W_BITS-1]}}, val[W_BITS-1:0]};
        end
        return val;
    endfunction

    // Request decode: effective operands and the locally resolved special result
    always_comb begin
        req_signed = ~req_op[0];
        req_rem    = req_op[1];
        if (req_w) begin
            eff_rs1   = {{(XLEN-W_BITS){1'b0}}, req_rs1[W_BITS-1:0]};
            eff_rs2   = {{(XLEN-W_BITS){1'b0}}, req_rs2[W_BITS-1:0]};
            most_neg  = (req_rs1[W_BITS-1:0] == {1'b1, {(W_BITS-1){1'b0}}});
            minus_one = &req_rs2[W_BITS-1:0];
        end else begin
            eff_rs1   = req_rs1;
            eff_rs2   = req_rs2;
            most_neg  = (req_rs1 == {1'b1, {(XLEN-1){1'b0}}});
            minus_one = &req_rs2;
        end
        div_zero = (eff_rs2 == '0);
        special  = div_zero | (req_signed & most_neg & minus_one);
        if (div_zero) begin
            special_raw = req_rem ? eff_rs1 : '1;
        end else begin
            special_raw = req_rem ? '0 : eff_rs1;
        end
        special_res = fmt_result(special_raw, req_w);
    end

    assign div_res    = fmt_result(op_rem ? div_rema : div_quot, op_w);
    assign req_ready  = (state == S_IDLE) & div_ready;
    assign accept     = req_valid & req_ready & ~flush;
    assign resp_valid = (state == S_RESP) & ~flush;
    assign busy       = (state != S_IDLE) | (req_valid & req_ready);
    assign div_valid  = (state == S_ISSUE);
    assign div_flush  = (state == S_DRAIN);
    assign div_signed = op_signed;
    assign divw       = op_w;
    assign dividend   = op_a;
    assign divisor    = op_b;
    assign resp_data  = resp_q;

    // Sequencer state; flush wins over a same-cycle divider strobe
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= special ? S_RESP : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (flush) begin
                        state <= div_out_valid ? S_IDLE : S_DRAIN;
                    end else if (div_out_valid) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (flush || resp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    if (div_out_valid || div_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Operand capture at accept and result capture (special or divider strobe)
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_signed <= 1'b0;
            op_rem    <= 1'b0;
            op_w      <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            resp_q    <= '0;
        end else begin
            if (state == S_IDLE && accept) begin
                op_signed <= req_signed;
                op_rem    <= req_rem;
                op_w      <= req_w;
                op_a      <= eff_rs1;
                op_b      <= eff_rs2;
                if (special) begin
                    resp_q <= special_res;
                end
            end
            if (state == S_ISSUE && div_out_valid && !flush) begin
                resp_q <= div_res;
            end
        end
    end

endmodule

// File: tb/tb_mdu_div_ctrl.sv
// Testbench for mdu_div_ctrl: directed RISC-V divide cases followed by random
// traffic, checked every cycle against a transaction-level reference model.
// The bench also plays the iterative divider.
module tb_mdu_div_ctrl;

    localparam int P_FREE  = 0;
    localparam int P_DIV   = 1;
    localparam int P_OUT   = 2;
    localparam int P_DRAIN = 3;
    localparam int D_IDLE  = 0;
    localparam int D_RUN   = 1;
    localparam int D_DONE  = 2;

    logic        clk = 1'b0;
    logic        reset, flush, req_valid, req_ready, req_w;
    logic [1:0]  req_op;
    logic [63:0] req_rs1, req_rs2;
    logic        resp_valid, resp_ready, busy;
    logic [63:0] resp_data;
    logic        div_valid, div_signed, divw, div_flush;
    logic [63:0] dividend, divisor;
    logic        div_ready, div_out_valid;
    logic [63:0] div_quot, div_rema;

    always #5 clk = ~clk;

    mdu_div_ctrl #(.XLEN(64), .W_BITS(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_w(req_w),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .busy(busy), .div_valid(div_valid), .div_signed(div_signed), .divw(divw),
        .dividend(dividend), .divisor(divisor), .div_flush(div_flush),
        .div_ready(div_ready), .div_out_valid(div_out_valid),
        .div_quot(div_quot), .div_rema(div_rema)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // stimulus requested for the next cycle
    logic        s_reset, s_flush, s_req_valid, s_w, s_resp_ready;
    logic [1:0]  s_op;
    logic [63:0] s_rs1, s_rs2;
    int          cfg_lat;
    logic        cfg_abort;

    // reference model
    int          ph;
    logic [63:0] exp_data, pend_data, exp_a, exp_b;
    logic        exp_sgn, exp_w;
    logic        e_req_ready, e_busy, e_resp_valid, e_div_valid, e_div_flush;
    logic        chk_en;

    // divider model
    int          dv_st, dv_cnt;
    logic        dv_abort;
    logic [63:0] dv_q, dv_r;
    logic [63:0] sn_dividend, sn_divisor;
    logic        sn_sgn, sn_w;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // RISC-V division semantics in plain arithmetic; W results in the low 32 bits
    function automatic void div_core(input logic sgn, input logic w,
                                     input logic [63:0] a, input logic [63:0] b,
                                     output logic [63:0] q, output logic [63:0] r);
        int                sa, sb;
        int unsigned       ua, ub;
        longint            sla, slb;
        longint unsigned   ula, ulb;
        logic [31:0]       q32, r32;
        if (w) begin
            sa = a[31:0]; sb = b[31:0]; ua = a[31:0]; ub = b[31:0];
            if (ub == 0) begin
                q32 = 32'hFFFFFFFF; r32 = a[31:0];
            end else if (sgn && a[31:0] == 32'h80000000 && b[31:0] == 32'hFFFFFFFF) begin
                q32 = a[31:0]; r32 = 32'h0;
            end else if (sgn) begin
                q32 = sa / sb; r32 = sa % sb;
            end else begin
                q32 = ua / ub; r32 = ua % ub;
            end
            q = {32'h0, q32};
            r = {32'h0, r32};
        end else begin
            sla = a; slb = b; ula = a; ulb = b;
            if (ulb == 0) begin
                q = 64'hFFFFFFFFFFFFFFFF; r = a;
            end else if (sgn && a == 64'h8000000000000000 && b == 64'hFFFFFFFFFFFFFFFF) begin
                q = a; r = 64'h0;
            end else if (sgn) begin
                q = sla / slb; r = sla % slb;
            end else begin
                q = ula / ulb; r = ula % ulb;
            end
        end
    endfunction

    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic w,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [63:0] q, r, v;
        div_core(!op[0], w, a, b, q, r);
        v = op[1] ? r : q;
        return w ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    function automatic logic is_special(input logic [1:0] op, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
        if (w) begin
            return (b[31:0] == 32'h0) ||
                   (!op[0] && a[31:0] == 32'h80000000 && b[31:0] == 32'hFFFFFFFF);
        end
        return (b == 64'h0) ||
               (!op[0] && a == 64'h8000000000000000 && b == 64'hFFFFFFFFFFFFFFFF);
    endfunction

    // apply the effect of the clock edge that just passed, using last cycle's inputs
    task automatic advance();
        logic [63:0] q, r;
        logic        acc;
        acc = req_valid && e_req_ready && !flush;
        if (!reset) begin
            ph = P_FREE; dv_st = D_IDLE; exp_data = 64'h0;
        end else begin
            case (dv_st)
                D_IDLE: if (e_div_valid) begin
                    dv_st = D_RUN; dv_cnt = cfg_lat; dv_abort = cfg_abort;
                    div_core(sn_sgn, sn_w, sn_dividend, sn_divisor, q, r);
                    dv_q = sn_w ? {$urandom, q[31:0]} : q;
                    dv_r = sn_w ? {$urandom, r[31:0]} : r;
                end
                D_RUN: begin
                    if (e_div_flush && dv_abort) dv_st = D_IDLE;
                    else if (dv_cnt <= 1) dv_st = D_DONE;
                    else dv_cnt--;
                end
                default: dv_st = D_IDLE;
            endcase
            case (ph)
                P_FREE: if (acc) begin
                    if (is_special(req_op, req_w, req_rs1, req_rs2)) begin
                        ph = P_OUT;
                        exp_data = ref_result(req_op, req_w, req_rs1, req_rs2);
                    end else begin
                        ph = P_DIV;
                        pend_data = ref_result(req_op, req_w, req_rs1, req_rs2);
                        exp_a   = req_w ? {32'h0, req_rs1[31:0]} : req_rs1;
                        exp_b   = req_w ? {32'h0, req_rs2[31:0]} : req_rs2;
                        exp_sgn = !req_op[0];
                        exp_w   = req_w;
                    end
                end
                P_DIV: begin
                    if (flush) ph = div_out_valid ? P_FREE : P_DRAIN;
                    else if (div_out_valid) begin ph = P_OUT; exp_data = pend_data; end
                end
                P_OUT:   if (flush || resp_ready) ph = P_FREE;
                default: if (div_out_valid || div_ready) ph = P_FREE;
            endcase
        end
    endtask

    task automatic tick();
        @(negedge clk);
        advance();
        reset = s_reset; flush = s_flush; req_valid = s_req_valid; req_op = s_op;
        req_w = s_w; req_rs1 = s_rs1; req_rs2 = s_rs2; resp_ready = s_resp_ready;
        div_ready     = (dv_st == D_IDLE);
        div_out_valid = (dv_st == D_DONE);
        div_quot      = (dv_st == D_DONE) ? dv_q : {$urandom, $urandom};
        div_rema      = (dv_st == D_DONE) ? dv_r : {$urandom, $urandom};
        e_req_ready  = (ph == P_FREE) && div_ready;
        e_busy       = (ph != P_FREE) || (req_valid && e_req_ready);
        e_resp_valid = (ph == P_OUT) && !flush;
        e_div_valid  = (ph == P_DIV);
        e_div_flush  = (ph == P_DRAIN);
        chk_en = 1'b1;
        #1;
        sn_dividend = dividend; sn_divisor = divisor; sn_sgn = div_signed; sn_w = divw;
    endtask

    // per-cycle comparison of DUT outputs against the model
    initial forever begin
        @(negedge clk);
        #2;
        if (chk_en) begin
            check1("req_ready", req_ready, e_req_ready);
            check1("busy", busy, e_busy);
            check1("resp_valid", resp_valid, e_resp_valid);
            check1("div_valid", div_valid, e_div_valid);
            check1("div_flush", div_flush, e_div_flush);
            if (ph == P_OUT) check64("resp_data", resp_data, exp_data);
            if (ph == P_DIV) begin
                check64("dividend", dividend, exp_a);
                check64("divisor", divisor, exp_b);
                check1("div_signed", div_signed, exp_sgn);
                check1("divw", divw, exp_w);
            end
        end
    end

    task automatic do_op(input string name, input logic [1:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] want, input int lat, input logic spec, input int hold);
        int n;
        cfg_lat = lat; cfg_abort = 1'b0;
        s_req_valid = 1'b0; s_resp_ready = 1'b0;
        tick(); #2;
        n = 0;
        while (!req_ready && n < 200) begin tick(); #2; n++; end
        check1({name, " ready before request"}, req_ready, 1'b1);
        s_req_valid = 1'b1; s_op = op; s_w = w; s_rs1 = a; s_rs2 = b;
        tick();
        s_req_valid = 1'b0;
        n = 0;
        do begin tick(); #2; n++; end while (!resp_valid && n < 200);
        check1({name, " resp_valid"}, resp_valid, 1'b1);
        check64({name, " resp_data"}, resp_data, want);
        if (spec) check_int({name, " latency"}, n, 1);
        for (int i = 0; i < hold; i++) begin
            tick(); #2;
            check1({name, " hold resp_valid"}, resp_valid, 1'b1);
            check64({name, " hold resp_data"}, resp_data, want);
            check1({name, " hold busy"}, busy, 1'b1);
        end
        s_resp_ready = 1'b1;
        tick(); #2;
        s_resp_ready = 1'b0;
        tick(); #2;
        check1({name, " busy after handshake"}, busy, 1'b0);
    endtask

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 64'h0;
            1:       return 64'h8000000000000000;
            2:       return 64'hFFFFFFFFFFFFFFFF;
            3:       return 64'h0000000080000000;
            4:       return 64'h00000000FFFFFFFF;
            5:       return {32'h0, $urandom_range(0, 20)};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_w = 1'b0;
        req_rs1 = 64'h0; req_rs2 = 64'h0; resp_ready = 1'b0;
        div_ready = 1'b1; div_out_valid = 1'b0; div_quot = 64'h0; div_rema = 64'h0;
        s_reset = 1'b0; s_flush = 1'b0; s_req_valid = 1'b0; s_op = 2'b00; s_w = 1'b0;
        s_rs1 = 64'h0; s_rs2 = 64'h0; s_resp_ready = 1'b0;
        cfg_lat = 4; cfg_abort = 1'b0;
        ph = P_FREE; dv_st = D_IDLE; dv_cnt = 0; dv_abort = 1'b0;
        exp_data = 64'h0; pend_data = 64'h0; exp_a = 64'h0; exp_b = 64'h0;
        exp_sgn = 1'b0; exp_w = 1'b0; dv_q = 64'h0; dv_r = 64'h0;
        e_req_ready = 1'b0; e_busy = 1'b0; e_resp_valid = 1'b0; e_div_valid = 1'b0;
        e_div_flush = 1'b0; chk_en = 1'b0;
        sn_dividend = 64'h0; sn_divisor = 64'h0; sn_sgn = 1'b0; sn_w = 1'b0;

        tick(); tick(); #2;
        check64("reset resp_data", resp_data, 64'h0);
        check64("reset dividend", dividend, 64'h0);
        check1("reset div_valid", div_valid, 1'b0);
        check1("reset busy", busy, 1'b0);
        s_reset = 1'b1;
        tick();

        do_op("DIV -7/2",   2'b00, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 6, 1'b0, 0);
        do_op("REM -7/2",   2'b10, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 3, 1'b0, 0);
        do_op("DIVU 100/0", 2'b01, 1'b0, 64'd100, 64'd0, 64'hFFFFFFFFFFFFFFFF, 4, 1'b1, 0);
        do_op("REMU 100/0", 2'b11, 1'b0, 64'd100, 64'd0, 64'd100, 4, 1'b1, 0);
        do_op("DIV ovf",    2'b00, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF,
              64'h8000000000000000, 4, 1'b1, 0);
        do_op("REM ovf",    2'b10, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h0, 4, 1'b1, 0);
        do_op("DIVW ovf",   2'b00, 1'b1, 64'h0000000080000000, 64'h00000000FFFFFFFF,
              64'hFFFFFFFF80000000, 4, 1'b1, 0);
        do_op("REMUW",      2'b11, 1'b1, 64'hFFFFFFFFFFFFFFF5, 64'h10, 64'h5, 4, 1'b0, 0);
        do_op("DIVUW",      2'b01, 1'b1, 64'h0000000080000000, 64'h1, 64'hFFFFFFFF80000000, 2, 1'b0, 0);
        do_op("DIV hold",   2'b00, 1'b0, 64'd100, 64'd7, 64'd14, 5, 1'b0, 5);

        // flush well into ISSUE; the divider runs on and strobes a stale result
        cfg_lat = 40; cfg_abort = 1'b0;
        s_req_valid = 1'b1; s_op = 2'b01; s_w = 1'b0; s_rs1 = 64'd1000; s_rs2 = 64'd7;
        tick();
        s_req_valid = 1'b0;
        repeat (20) tick();
        #2;
        check1("issue div_valid held", div_valid, 1'b1);
        s_flush = 1'b1;
        tick();
        s_flush = 1'b0;
        tick(); #2;
        check1("drain req_ready", req_ready, 1'b0);
        check1("drain div_flush", div_flush, 1'b1);
        n = 0;
        while (!req_ready && n < 100) begin tick(); #2; n++; end
        check1("drain exit", req_ready, 1'b1);
        do_op("DIVU 9/3", 2'b01, 1'b0, 64'd9, 64'd3, 64'd3, 3, 1'b0, 0);

        // reset mid-ISSUE
        cfg_lat = 30;
        s_req_valid = 1'b1; s_op = 2'b00; s_rs1 = 64'd1000; s_rs2 = 64'd3;
        tick();
        s_req_valid = 1'b0;
        repeat (5) tick();
        #2;
        check1("pre-reset div_valid", div_valid, 1'b1);
        s_reset = 1'b0;
        tick();
        s_reset = 1'b1;
        tick(); #2;
        check1("mid reset div_valid", div_valid, 1'b0);
        check1("mid reset busy", busy, 1'b0);
        check1("mid reset resp_valid", resp_valid, 1'b0);
        check64("mid reset dividend", dividend, 64'h0);
        check64("mid reset divisor", divisor, 64'h0);
        check1("mid reset div_signed", div_signed, 1'b0);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            s_reset      = ($urandom_range(0, 599) != 0);
            s_flush      = ($urandom_range(0, 39) == 0);
            s_resp_ready = ($urandom_range(0, 2) != 0);
            s_req_valid  = ($urandom_range(0, 1) != 0);
            s_op  = 2'($urandom_range(0, 3));
            s_w   = ($urandom_range(0, 1) != 0);
            s_rs1 = rnd_operand();
            s_rs2 = rnd_operand();
            cfg_lat   = $urandom_range(1, 12);
            cfg_abort = ($urandom_range(0, 1) != 0);
            tick();
        end
        s_reset = 1'b1; s_flush = 1'b0; s_req_valid = 1'b0; s_resp_ready = 1'b1;
        repeat (60) tick();
        #2;
        check1("final idle busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_div_ctrl.md
Name: mdu_div_ctrl

Overview:
- EX-stage sequencer between the issue logic and the 64-bit iterative divider.
- Decodes RISC-V DIV/DIVU/REM/REMU and their W forms, and resolves divide-by-zero and signed-overflow locally with a short fixed latency.
- Drives the divider handshake for all other operations, captures the one-cycle divider result, and selects quotient or remainder; W results are sign-extended.
- Presents the result to writeback on a valid/ready handshake and stalls the pipeline while busy.

Parameters:
XLEN, 64, operand/result width; the divider is fixed at 64.
W_BITS, 32, operand width for W-form operations.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
flush  in  1  pipeline flush; kills any in-flight operation
req_valid  in  1  divide request present
req_ready  out  1  block can accept a request
req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
req_w  in  1  W-form (32-bit) operation
req_rs1  in  XLEN  dividend
req_rs2  in  XLEN  divisor
resp_valid  out  1  result valid
resp_ready  in  1  writeback accepts result
resp_data  out  XLEN  result
busy  out  1  stall request to the pipeline
div_valid  out  1  to divider
div_signed  out  1  to divider
divw  out  1  to divider
dividend  out  XLEN  to divider
divisor  out  XLEN  to divider
div_flush  out  1  to divider
div_ready  in  1  divider idle
div_out_valid  in  1  divider result strobe, one cycle
div_quot  in  XLEN  divider quotient
div_rema  in  XLEN  divider remainder

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; resp_valid=0, resp_data=0, div_valid=0, busy=0, div_flush=0; operand registers cleared.
- req_ready = (state==IDLE) && div_ready. A request is accepted when req_valid && req_ready.
- Signed = (req_op==DIV || req_op==REM). Effective operands are the low 32 bits when req_w=1, otherwise the full 64 bits.
- Special cases are decided at accept and bypass the divider:
  - Divide by zero (effective divisor==0): quotient = all ones; remainder = effective dividend.
  - Signed overflow (signed, dividend = most negative, divisor = -1): quotient = dividend; remainder = 0.
- Result select: DIV/DIVU return the quotient; REM/REMU return the remainder.
- W forms: resp_data = sign-extension of bit 31 of the 32-bit result, including DIVUW and REMUW. Example: DIVUW of 0x80000000 by 1 returns 0xFFFFFFFF80000000.
- States:
  - IDLE: on accept, special case -> RESP with the result registered; otherwise -> ISSUE.
  - ISSUE: div_valid=1 with dividend, divisor, div_signed and divw taken from the registered operands.
    - These outputs stay stable and div_valid stays high through the cycle div_out_valid=1 inclusive. The divider derives result signs combinationally from its inputs, so this is mandatory.
    - In the div_out_valid cycle: capture quot/rema, apply result select and W extension, -> RESP.
    - Then deassert div_valid on the next edge.
  - RESP: resp_valid=1 and resp_data stable until resp_ready; on resp_valid && resp_ready -> IDLE.
  - DRAIN: entered on flush while in ISSUE.
    - div_valid=0 and div_flush=1.
    - Wait for div_out_valid or div_ready, discard the result, then -> IDLE.
    - req_ready=0 throughout.
- busy = (state != IDLE) || (req_valid && req_ready). It deasserts on the cycle after the RESP handshake.
- Flush behaviour:
  - Flush in IDLE: no effect.
  - Flush in RESP: drops resp_valid; -> IDLE on the next edge.
  - Flush in the same cycle as an accept: the request is ignored.
  - Flush has priority over div_out_valid in the same cycle; the result is discarded and the block goes to IDLE.
- Latency:
  - Special case: resp_valid the cycle after accept.
  - Normal operation: resp_valid the cycle after div_out_valid.
- A synchronous reset mid-operation returns the block to IDLE immediately. The divider shares the reset net, so it is not separately drained.

Test Plan:
- DIV rs1=-7 (0xFFFFFFFFFFFFFFF9), rs2=2 -> resp_data=0xFFFFFFFFFFFFFFFD. REM of the same operands -> 0xFFFFFFFFFFFFFFFF. div_valid is held high until the out_valid cycle.
- DIVU rs1=100, rs2=0 -> resp_data=0xFFFFFFFFFFFFFFFF one cycle after accept, with div_valid never asserted. REMU of the same operands -> 100.
- DIV rs1=0x8000000000000000, rs2=-1 -> quotient 0x8000000000000000; REM -> 0. DIVW rs1=0x80000000, rs2=0xFFFFFFFF -> 0xFFFFFFFF80000000.
- REMUW rs1=0xFFFFFFFF_FFFFFFF5, rs2=0x10 -> 0x0000000000000005. DIVUW rs1=0x80000000, rs2=1 -> 0xFFFFFFFF80000000.
- Flush 20 cycles into ISSUE -> block enters DRAIN with req_ready=0 until the divider returns idle; the next DIVU 9/3 request returns 3 and the stale result is never presented.
- resp_ready held low for 5 cycles during RESP -> resp_valid and resp_data stay stable and busy stays 1. Reset asserted low mid-ISSUE -> all outputs return to 0 on the next edge.
